// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and saturating stall counter.
// Optional PIPE_SKID_EN macro adds a second (skid) entry so in_ready becomes a pure register output.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, drain, stall;

    assign drain  = main_valid_q & out_ready;
    assign stall  = main_valid_q & ~out_ready;
    assign accept = in_valid & in_ready & ~flush;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    // Registered ready: the skid slot absorbs the one beat in flight when main stalls.
    assign in_ready = ~skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = in_data;
                main_ctrl_d  = in_ctrl;
            end else begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end else if (main_valid_q) begin
            if (accept) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_ctrl_d  = in_ctrl;
            end
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end
`else
    // Single entry: ready whenever the slot is empty or being vacated this cycle.
    assign in_ready = ~main_valid_q | out_ready | flush;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
        end else if (drain) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
        end
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;
    localparam int DW = 128;
    localparam int CW = 12;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          flush = 1'b0;
    logic          out_valid, out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          stall_clr = 1'b0;
    logic [NW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;
    ent_t          mq[$];
    logic [DW-1:0] m_last;
    int            m_cnt;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
`ifdef PIPE_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || out_ready || flush;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        m_cnt  = 0;
    endtask

    task automatic check_all();
        chk("out_valid", DW'(out_valid), DW'(mq.size() > 0));
        chk("out_data", out_data, (mq.size() > 0) ? mq[0].d : m_last);
        chk("out_ctrl", DW'(out_ctrl), (mq.size() > 0) ? DW'(mq[0].c) : '0);
        chk("in_ready", DW'(in_ready), DW'(model_ready()));
        chk("stall_cnt", DW'(stall_cnt), DW'(m_cnt));
    endtask

    // Inputs are stable during the posedge; model advances with the same inputs.
    task automatic model_update();
        logic rdy, stl;
        rdy = model_ready();
        stl = (mq.size() > 0) && !out_ready;
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) mq.push_back('{d: in_data, c: in_ctrl});
        end
        if (mq.size() > 0) m_last = mq[0].d;
        if (stall_clr) m_cnt = 0;
        else if (stl && m_cnt < (2**NW - 1)) m_cnt++;
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl, input logic clr);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        stall_clr = clr;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_out_valid", DW'(out_valid), '0);
        chk("reset_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;

        // Reset mid-stream with a live entry carrying ctrl ABC
        drive(1'b1, DW'(32'h1234), 12'hABC, 1'b0, 1'b0, 1'b0);
        step();
        chk("pre_reset_ctrl", DW'(out_ctrl), DW'(12'hABC));
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", DW'(out_valid), '0);
        chk("async_rst_ctrl", DW'(out_ctrl), '0);
        chk("async_rst_cnt", DW'(stall_cnt), '0);
        chk("async_rst_data", out_data, '0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Streaming 1,2,3..
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b0);
            step();
            chk("stream_data", out_data, DW'(i));
            chk("stream_valid", DW'(out_valid), DW'(1));
        end

        // Stall with D=5 held for four cycles
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, DW'(5), CW'(5), 1'b0, 1'b0, 1'b0);
        step();
`ifdef PIPE_SKID_EN
        drive(1'b1, DW'(6), CW'(6), 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
`else
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (4) step();
`endif
        chk("stall_data", out_data, DW'(5));
        chk("stall_cnt4", DW'(stall_cnt), DW'(4));
        chk("stall_in_ready", DW'(in_ready), '0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step();
`ifdef PIPE_SKID_EN
        chk("skid_order", out_data, DW'(6));
        step();
`endif
        chk("drained", DW'(out_valid), '0);

        // Flush kills held and incoming entries
        drive(1'b1, DW'(7), CW'(7), 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, DW'(8), CW'(8), 1'b0, 1'b1, 1'b0);
        step();
        chk("flush_valid", DW'(out_valid), '0);
        chk("flush_ctrl", DW'(out_ctrl), '0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step();
        chk("flush_no_ghost", DW'(out_valid), '0);

        // Saturation and clear priority
        drive(1'b1, DW'(9), CW'(9), 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (20) step();
        chk("cnt_saturate", DW'(stall_cnt), DW'(15));
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step();
        chk("cnt_clear", DW'(stall_cnt), '0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, {$urandom, $urandom, $urandom, $urandom}, CW'($urandom),
                  (i % 200 < 150) ? (($urandom % 3) != 0) : (($urandom % 8) == 0),
                  ($urandom % 20) == 0, ($urandom % 40) == 0);
            step();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bubble invariant checked continuously on the opposite edge
    always @(negedge clk) begin
        if (rst && !out_valid) chk("bubble_ctrl", DW'(out_ctrl), '0);
    end
endmodule
